seq_det_scheduler: RTL and testbench
====================================

Name: seq_det_scheduler

Overview:
- Shares one pattern-match engine (overlapping serial sequence detector) among NCH serial bit-stream requesters.
- A round-robin scheduler grants one bit per cycle. Per-channel context (bit history and fill count) is saved in registers, so each stream detects independently.
- Detection events are reported as one-cycle pulses tagged with the channel. Optional per-channel hit counters are provided.
- Sits between the button/serial input conditioners and the display/LED logic of the lab top level.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- PAT_LEN, 4, pattern length in bits (2..8).
- CNT_W, 8, width of each per-channel hit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_pattern  in  PAT_LEN  pattern to detect; bit PAT_LEN-1 is the oldest bit.
- cfg_load  in  1  captures cfg_pattern and clears all channel contexts.
- bit_valid  in  NCH  per-channel bit offered.
- bit_data  in  NCH  per-channel serial bit.
- bit_ready  out  NCH  one-hot grant; a bit transfers when bit_valid[c] && bit_ready[c].
- det_valid  out  1  one-cycle detection pulse.
- det_ch  out  $clog2(NCH)  channel of the detection.
- cnt_clr  in  1  clears all hit counters.
- det_count  out  NCH*CNT_W  packed hit counters; channel c is at [c*CNT_W +: CNT_W].

Behaviour:
- Reset state: FSM=IDLE, pattern reg=0, all histories=0, fill=0, rr pointer=0, bit_ready=0, det_valid=0, det_ch=0, counters=0.
- FSM states:
  - IDLE: bit_ready=0. Moves to FLUSH on cfg_load.
  - FLUSH: one cycle. Pattern is already captured; clears hist/fill for all channels; bit_ready=0. Always moves to RUN.
  - RUN: arbitrates every cycle. cfg_load moves to FLUSH, captures cfg_pattern and forces bit_ready=0 in that same cycle.
- Arbitration in RUN:
  - bit_ready is combinational from bit_valid and the rr pointer.
  - The grant goes to the first requesting channel at or after the pointer, modulo NCH.
  - After a transfer, the pointer moves to granted+1 (wraps NCH-1 to 0).
  - The pointer holds if there is no request.
  - At most one bit_ready is high. bit_ready=0 when no bit_valid is set.
- Context update on transfer for channel c:
  - hist[c] <= {hist[c][PAT_LEN-2:0], bit_data[c]}.
  - fill[c] increments, saturating at PAT_LEN.
- Match condition, evaluated in the transfer cycle: {hist[c][PAT_LEN-2:0], bit_data[c]} == pattern AND fill[c] >= PAT_LEN-1.
- Match reporting:
  - det_valid=1 and det_ch=c are registered one cycle after the transfer.
  - det_valid is 0 in any cycle not following a matching transfer.
- Overlap: history is not cleared on a match. With pattern 1010, input 1010 10 yields two hits.
- Counters:
  - det_count[c] increments on a match and saturates at 2^CNT_W-1.
  - cnt_clr takes priority over a simultaneous increment (result 0).
  - cfg_load does not clear counters.
- Simultaneous cfg_load and a pending match from the previous cycle: the det_valid pulse still issues.
- Reset mid-stream: all state returns to reset values on the next edge. Transfers in the reset cycle are ignored.

Optional Feature:
- Macro: SEQ_DET_SCHED_STATS_EN.
- Defined: hit counters and cnt_clr are implemented as described.
- Undefined: no counter flops are built, det_count is tied to 0, cnt_clr is ignored. Detection and arbitration are unchanged.

Decomposition:
- Package seq_det_pkg:
  - FSM state enum (IDLE, FLUSH, RUN).
  - Default NCH/PAT_LEN/CNT_W localparams.
  - Function for clog2-sized channel index width.
- Sub-module rr_arbiter (parameter N) holds the pointer and the combinational one-hot grant logic; inputs req, advance; output grant.
- Context storage, match compare and counters stay in seq_det_scheduler.

Test Plan:
- Reset then no cfg_load, all bit_valid=1 -> bit_ready stays 0 and det_valid=0 for 20 cycles.
- cfg_load with pattern 1101, then channel 0 alone sends 1,1,0,1,1,0,1 -> det_valid with det_ch=0 one cycle after the 4th and 7th transfers; det_count[0]=2.
- All four channels hold bit_valid=1 -> grants rotate 0,1,2,3,0 on consecutive cycles. Drop channel 2 -> sequence becomes 0,1,3,0.
- Interleaved streams: ch1 sends 1101 and ch3 sends 1100, alternating grants -> exactly one det_valid with det_ch=1; ch3 count stays 0.
- cfg_load mid-stream after ch0 sent 110 (new pattern 1101), then ch0 sends 1 -> no hit because fill was cleared; a full 1101 afterward -> hit.
- With CNT_W=2, 5 hits on ch2 -> det_count[2]=3 (saturated); cnt_clr asserted in the same cycle as a hit -> 0. With the macro undefined -> det_count=0 throughout.

Source files
------------

// File: rtl/seq_det_scheduler_pkg.sv
// Shared types and defaults for the time-multiplexed sequence detector.
package seq_det_pkg;

  localparam int DEF_NCH     = 4;
  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Width of a channel index; never zero, even for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating pointer.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int N = DEF_NCH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = ch_idx_w(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_next_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;
  int            w_k;

  // NOTE: every output of this block is given a default first so no path leaves a latch.
  always_comb begin
    grant      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_k        = 0;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      w_k = int'(r_ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      w_idx = IW'(w_k);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_next_ptr   = (w_k == N - 1) ? '0 : IW'(w_k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= '0;
    else if (advance) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// One overlapping pattern matcher shared by NCH serial streams via round-robin.
// SEQ_DET_SCHED_STATS_EN adds saturating per-channel hit counters and cnt_clr.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PAT_LEN-1:0]     cfg_pattern,
  input  logic                   cfg_load,
  input  logic [NCH-1:0]         bit_valid,
  input  logic [NCH-1:0]         bit_data,
  output logic [NCH-1:0]         bit_ready,
  output logic                   det_valid,
  output logic [$clog2(NCH)-1:0] det_ch,
  input  logic                   cnt_clr,
  output logic [NCH*CNT_W-1:0]   det_count
);

  localparam int IW = ch_idx_w(NCH);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] ST_RUN   = RUN;

  logic [1:0]         r_state;
  logic [PAT_LEN-1:0] r_pattern;
  logic [PAT_LEN-2:0] r_hist [NCH];
  logic [FW-1:0]      r_fill [NCH];
  logic               r_det_valid;
  logic [IW-1:0]      r_det_ch;

  logic [NCH-1:0]     w_req;
  logic [NCH-1:0]     w_grant;
  logic               w_xfer;
  logic [IW-1:0]      w_gidx;
  logic [PAT_LEN-1:0] w_shift;
  logic               w_match;

  // A reconfiguration cycle must not move bits under the old pattern.
  assign w_req  = (r_state == ST_RUN && !cfg_load) ? bit_valid : '0;
  assign w_xfer = |w_grant;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_grant[c]) w_gidx = IW'(c);
    end
  end

  assign w_shift = {r_hist[w_gidx], bit_data[w_gidx]};
  assign w_match = w_xfer && (w_shift == r_pattern) && (r_fill[w_gidx] >= FW'(PAT_LEN - 1));

  // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
    end else begin
      if (cfg_load) r_pattern <= cfg_pattern;
      case (r_state)
        ST_IDLE:  if (cfg_load) r_state <= ST_FLUSH;
        ST_FLUSH: r_state <= ST_RUN;
        ST_RUN:   if (cfg_load) r_state <= ST_FLUSH;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || r_state == ST_FLUSH) begin
        r_hist[c] <= '0;
        r_fill[c] <= '0;
      end else if (w_grant[c]) begin
        r_hist[c] <= w_shift[PAT_LEN-2:0];
        if (r_fill[c] != FW'(PAT_LEN)) r_fill[c] <= r_fill[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
    end else begin
      r_det_valid <= w_match;
      if (w_match) r_det_ch <= w_gidx;
    end
  end

  assign bit_ready = w_grant;
  assign det_valid = r_det_valid;
  assign det_ch    = r_det_ch;

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [CNT_W-1:0] r_cnt [NCH];

  // Clear wins over a same-cycle hit.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || cnt_clr) r_cnt[c] <= '0;
      else if (w_match && w_gidx == IW'(c) && r_cnt[c] != '1) r_cnt[c] <= r_cnt[c] + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign det_count[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`else
  logic w_unused;
  assign w_unused  = cnt_clr;
  assign det_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed and random stimulus against a queue-based model of the shared detector.
module tb_seq_det_scheduler;

  localparam int NCH     = 4;
  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef SEQ_DET_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [PAT_LEN-1:0]   cfg_pattern;
  logic                 cfg_load;
  logic [NCH-1:0]       bit_valid;
  logic [NCH-1:0]       bit_data;
  logic [NCH-1:0]       bit_ready;
  logic                 det_valid;
  logic [1:0]           det_ch;
  logic                 cnt_clr;
  logic [NCH*CNT_W-1:0] det_count;

  seq_det_scheduler #(.NCH(NCH), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pattern (cfg_pattern),
    .cfg_load    (cfg_load),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .det_valid   (det_valid),
    .det_ch      (det_ch),
    .cnt_clr     (cnt_clr),
    .det_count   (det_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = flush, 2 = run; each channel keeps the bits received since the last flush.
  int                 m_state;
  logic [PAT_LEN-1:0] m_pat;
  int                 m_ptr;
  bit                 m_q [NCH][$];
  int                 m_cnt [NCH];
  bit                 m_det_v;
  int                 m_det_ch;
  logic [NCH-1:0]     exp_grant;
  int                 exp_gch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state  = 0;
    m_pat    = '0;
    m_ptr    = 0;
    m_det_v  = 1'b0;
    m_det_ch = 0;
    for (int c = 0; c < NCH; c++) begin
      m_q[c].delete();
      m_cnt[c] = 0;
    end
  endfunction

  function automatic void compute_grant();
    int k;
    exp_grant = '0;
    exp_gch   = -1;
    if (m_state == 2 && !cfg_load) begin
      for (int i = 0; i < NCH; i++) begin
        k = (m_ptr + i) % NCH;
        if (exp_gch < 0 && bit_valid[k]) exp_gch = k;
      end
    end
    if (exp_gch >= 0) exp_grant[exp_gch] = 1'b1;
  endfunction

  // True when the stream for channel c, extended by b, ends with the pattern (oldest bit first).
  function automatic bit match_now(input int c, input bit b);
    int n;
    bit v;
    n = m_q[c].size() + 1;
    if (n < PAT_LEN) return 1'b0;
    for (int k = 0; k < PAT_LEN; k++) begin
      v = (k == PAT_LEN - 1) ? b : m_q[c][n - PAT_LEN + k];
      if (v != m_pat[PAT_LEN-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [NCH*CNT_W-1:0] exp_counts();
    logic [NCH*CNT_W-1:0] e;
    e = '0;
    if (STATS) begin
      for (int c = 0; c < NCH; c++) e[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    end
    return e;
  endfunction

  task automatic tick();
    bit b;
    bit hit;
    @(negedge clk);
    compute_grant();
    check("bit_ready", 32'(bit_ready), 32'(exp_grant));
    check("det_valid", 32'(det_valid), 32'(m_det_v));
    check("det_ch",    32'(det_ch),    32'(m_det_ch));
    check("det_count", 32'(det_count), 32'(exp_counts()));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_det_v = 1'b0;
      if (exp_gch >= 0) begin
        b   = bit_data[exp_gch];
        hit = match_now(exp_gch, b);
        m_q[exp_gch].push_back(b);
        if (m_q[exp_gch].size() > PAT_LEN) void'(m_q[exp_gch].pop_front());
        if (hit) begin
          m_det_v  = 1'b1;
          m_det_ch = exp_gch;
          if (m_cnt[exp_gch] < CMAX) m_cnt[exp_gch]++;
        end
        m_ptr = (exp_gch + 1) % NCH;
      end
      if (cnt_clr) for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      if (cfg_load) m_pat = cfg_pattern;
      case (m_state)
        0: if (cfg_load) m_state = 1;
        1: begin
          for (int c = 0; c < NCH; c++) m_q[c].delete();
          m_state = 2;
        end
        default: if (cfg_load) m_state = 1;
      endcase
    end
    #1;
  endtask

  task automatic load(input logic [PAT_LEN-1:0] p);
    cfg_pattern = p;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
    tick();
  endtask

  task automatic send(input int ch, input bit b);
    bit_valid     = '0;
    bit_valid[ch] = 1'b1;
    bit_data[ch]  = b;
    tick();
    bit_valid     = '0;
  endtask

  task automatic send_word(input int ch, input logic [3:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send(ch, w[i]);
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(det_count[c*CNT_W +: CNT_W]);
  endfunction

  initial begin
    logic [3:0] s1;
    logic [3:0] s3;
    rst         = 1'b1;
    cfg_pattern = '0;
    cfg_load    = 1'b0;
    bit_valid   = '0;
    bit_data    = '0;
    cnt_clr     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // No configuration yet: requests must be ignored.
    bit_valid = '1;
    repeat (20) tick();
    bit_valid = '0;

    load(4'b1101);
    send_word(0, 4'b1101, 4);
    send_word(0, 4'b0101, 3);
    tick();
    check("ch0_two_hits", cnt_of(0), STATS ? 32'd2 : 32'd0);

    bit_data  = '0;
    bit_valid = '1;
    repeat (8) tick();
    bit_valid = 4'b1011;
    repeat (8) tick();
    bit_valid = '0;
    tick();

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    load(4'b1101);
    s1 = 4'b1101;
    s3 = 4'b1100;
    for (int k = 3; k >= 0; k--) begin
      send(1, s1[k]);
      send(3, s3[k]);
    end
    tick();
    check("ch1_one_hit", cnt_of(1), STATS ? 32'd1 : 32'd0);
    check("ch3_no_hit",  cnt_of(3), 32'd0);

    // Reload mid-word: the partial 110 must be forgotten.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    load(4'b1101);
    send_word(0, 4'b0110, 3);
    load(4'b1101);
    send(0, 1'b1);
    tick();
    check("ch0_flushed", cnt_of(0), 32'd0);
    send_word(0, 4'b1101, 4);
    tick();
    check("ch0_after_flush", cnt_of(0), STATS ? 32'd1 : 32'd0);

    // Five overlapping hits on ch2 saturate the 2-bit counter.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    send_word(2, 4'b1101, 4);
    repeat (4) send_word(2, 4'b0101, 3);
    tick();
    check("ch2_saturated", cnt_of(2), STATS ? 32'd3 : 32'd0);
    send_word(2, 4'b0010, 2);
    cnt_clr = 1'b1;
    send(2, 1'b1);
    cnt_clr = 1'b0;
    tick();
    check("ch2_clr_wins", cnt_of(2), 32'd0);

    // A detection pending when cfg_load arrives still pulses.
    send_word(1, 4'b1101, 4);
    cfg_pattern = 4'b0110;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
    tick();

    // Reset mid-stream with every channel requesting.
    bit_valid = '1;
    bit_data  = 4'b1011;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bit_valid = '0;

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 399) == 0);
      cfg_pattern = PAT_LEN'($urandom);
      cfg_load    = (m_state == 0) || (m_state == 2 && $urandom_range(0, 149) == 0);
      cnt_clr     = ($urandom_range(0, 59) == 0);
      bit_valid   = NCH'($urandom);
      bit_data    = NCH'($urandom);
      tick();
    end
    rst       = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
    bit_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
